// File: rtl/value_entry_queue_if.sv
// Value-entry handshake bundle: direct value load on the input side and
// ready/valid queue-head delivery on the output side.
interface value_entry_queue_if #(
  parameter int WIDTH = 8
);
  logic             io_input_trigger;
  logic [WIDTH-1:0] io_input_value;
  logic             io_output_ready;
  logic             io_output_valid;
  logic [WIDTH-1:0] io_output_value;

  modport master (
    output io_input_trigger,
    output io_input_value,
    output io_output_ready,
    input  io_output_valid,
    input  io_output_value
  );

  modport slave (
    input  io_input_trigger,
    input  io_input_value,
    input  io_output_ready,
    output io_output_valid,
    output io_output_value
  );
endinterface

// File: rtl/value_entry_queue.sv
// Button-driven value editor: a debounced button FSM edits a shift register
// whose value can be committed into a small FIFO drained over ready/valid.
module value_entry_queue #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LED_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4:0]                 buttons,
  input  logic                       timer_active_trigger,
  value_entry_queue_if.slave         io,
  output logic [LED_WIDTH-1:0]       leds,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE         = 1'b0,
    WAIT_RELEASE = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] edit_reg, edit_next;
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic [WIDTH-1:0] mem [DEPTH];

  logic push, clear, pop, full, push_accept;

  // io_input_trigger pre-empts the button FSM entirely for that cycle.
  always_comb begin
    state_next = state_reg;
    edit_next  = edit_reg;
    push       = 1'b0;
    clear      = 1'b0;
    if (io.io_input_trigger) begin
      edit_next = io.io_input_value;
    end else if (timer_active_trigger) begin
      case (state_reg)
        IDLE: begin
          if (buttons != 5'b0) begin
            state_next = WAIT_RELEASE;
            if (buttons[1])      edit_next = {edit_reg[WIDTH-2:0], 1'b1};
            else if (buttons[0]) edit_next = {edit_reg[WIDTH-2:0], 1'b0};
            else if (buttons[4]) edit_next = edit_reg >> 1;
            else if (buttons[2]) begin
              edit_next = '0;
              clear     = 1'b1;
            end else             push      = 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (buttons == 5'b0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign full        = (count_reg == CW'(DEPTH));
  assign pop         = (count_reg != '0) && io.io_output_ready;
  // A same-cycle pop frees the slot a push into a full queue needs.
  assign push_accept = push && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    overflow_next = overflow_reg;
    if (clear)                     overflow_next = 1'b0;
    else if (push && !push_accept) overflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      edit_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edit_reg     <= edit_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      if (push_accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)         rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr_reg] <= edit_reg;
  end

  assign io.io_output_valid = (count_reg != '0);
  assign io.io_output_value = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count              = count_reg;
  assign overflow           = overflow_reg;

  for (genvar gi = 0; gi < LED_WIDTH; gi++) begin : g_led
    assign leds[gi] = edit_reg[gi];
  end
endmodule
